// File: rtl/nes_bus_ram.sv
// Parametrised NES CPU-bus RAM slave with mirrored decode, registered reads and a post-reset clear sweep.
// Read data appears one cycle after an accepted read; accesses arriving while the clear sweep runs are dropped.
module nes_bus_ram #(
  parameter int                ADDR_W         = 16,
  parameter int                DATA_W         = 8,
  parameter int                DEPTH_LOG2     = 11,
  parameter int                WINDOW_LOG2    = 13,
  parameter logic [ADDR_W-1:0] BASE_ADDR      = '0,
  parameter bit                CLEAR_ON_RESET = 1'b1,
  parameter logic [DATA_W-1:0] CLEAR_VALUE    = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              rw_n,
  input  logic              cs_n,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_valid,
  output logic              hit,
  output logic              ready,
  output logic              busy
);

  typedef enum logic {S_CLEAR, S_IDLE} state_e;

  state_e                  state_q;
  logic [DEPTH_LOG2-1:0]   clr_cnt_q;
  logic [DEPTH_LOG2-1:0]   clr_cnt_d;
  logic                    clr_last;
  logic                    busy_q;
  logic [DATA_W-1:0]       rdata_q;
  logic                    rdata_valid_q;

  logic [DATA_W-1:0]       mem [2**DEPTH_LOG2];

  logic [DEPTH_LOG2-1:0]   idx;
  logic                    accept;
  logic                    rd_acc;
  logic                    wr_acc;
  logic                    clearing;
  logic                    mem_we;
  logic [DEPTH_LOG2-1:0]   mem_waddr;
  logic [DATA_W-1:0]       mem_wdata;
  logic                    unused_addr;

  // A window spanning the whole bus decodes on chip select alone.
  generate
    if (WINDOW_LOG2 >= ADDR_W) begin : g_full_window
      assign hit = !cs_n;
    end else begin : g_sub_window
      assign hit = !cs_n && (addr[ADDR_W-1:WINDOW_LOG2] == BASE_ADDR[ADDR_W-1:WINDOW_LOG2]);
    end
  endgenerate

  // Address bits between the storage depth and the window size are ignored, mirroring the RAM.
  assign idx         = addr[DEPTH_LOG2-1:0];
  assign unused_addr = ^addr;

  assign accept   = hit && !busy_q;
  assign rd_acc   = accept && rw_n;
  assign wr_acc   = accept && !rw_n;
  assign clearing = (state_q == S_CLEAR);

  assign clr_cnt_d = clr_cnt_q + DEPTH_LOG2'(1);
  assign clr_last  = (clr_cnt_q == {DEPTH_LOG2{1'b1}});

  assign mem_we    = !rst && (clearing || wr_acc);
  assign mem_waddr = clearing ? clr_cnt_q : idx;
  assign mem_wdata = clearing ? CLEAR_VALUE : wdata;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= CLEAR_ON_RESET ? S_CLEAR : S_IDLE;
      clr_cnt_q     <= '0;
      busy_q        <= CLEAR_ON_RESET;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
    end else begin
      rdata_valid_q <= rd_acc;
      if (rd_acc) begin
        rdata_q <= mem[idx];
      end
      case (state_q)
        S_CLEAR: begin
          clr_cnt_q <= clr_cnt_d;
          if (clr_last) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign rdata       = rdata_q;
  assign rdata_valid = rdata_valid_q;
  assign busy        = busy_q;
  assign ready       = !busy_q;

endmodule

// File: tb/tb_nes_bus_ram.sv
// Directed bench for nes_bus_ram: one instance clears on reset, a second skips the clear.
module tb_nes_bus_ram;

  logic        clk;
  logic        rst,   rst_b;
  logic [15:0] addr,  addr_b;
  logic [7:0]  wdata, wdata_b;
  logic        rw_n,  rw_n_b;
  logic        cs_n,  cs_n_b;
  logic [7:0]  rdata_a, rdata_b;
  logic        valid_a, valid_b;
  logic        hit_a,   hit_b;
  logic        ready_a, ready_b;
  logic        busy_a,  busy_b;

  int checks = 0;
  int errors = 0;
  int n;
  logic [7:0] qa[$];
  logic [7:0] qb[$];

  nes_bus_ram dut_a (
    .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .rw_n(rw_n), .cs_n(cs_n),
    .rdata(rdata_a), .rdata_valid(valid_a), .hit(hit_a), .ready(ready_a), .busy(busy_a)
  );

  nes_bus_ram #(.CLEAR_ON_RESET(1'b0)) dut_b (
    .clk(clk), .rst(rst_b), .addr(addr_b), .wdata(wdata_b), .rw_n(rw_n_b), .cs_n(cs_n_b),
    .rdata(rdata_b), .rdata_valid(valid_b), .hit(hit_b), .ready(ready_b), .busy(busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample just after the edge; any valid pulse is matched against the scoreboard.
  task automatic tick();
    logic [7:0] e;
    @(posedge clk);
    #1;
    if (valid_a) begin
      chk("valid_a_expected", 32'(qa.size() != 0), 32'd1);
      if (qa.size() != 0) begin
        e = qa.pop_front();
        chk("rdata_a", 32'(rdata_a), 32'(e));
      end
    end
    if (valid_b) begin
      chk("valid_b_expected", 32'(qb.size() != 0), 32'd1);
      if (qb.size() != 0) begin
        e = qb.pop_front();
        chk("rdata_b", 32'(rdata_b), 32'(e));
      end
    end
  endtask

  task automatic wr_a(input logic [15:0] a, input logic [7:0] d);
    cs_n = 1'b0; rw_n = 1'b0; addr = a; wdata = d;
    tick();
  endtask

  task automatic rd_a(input logic [15:0] a, input logic [7:0] exp);
    cs_n = 1'b0; rw_n = 1'b1; addr = a;
    qa.push_back(exp);
    tick();
    chk("rd_valid_a", 32'(valid_a), 32'd1);
  endtask

  task automatic idle_a();
    cs_n = 1'b1; rw_n = 1'b1;
    tick();
  endtask

  initial begin
    rst   = 1'b1; cs_n   = 1'b1; rw_n   = 1'b1; addr   = '0; wdata   = '0;
    rst_b = 1'b1; cs_n_b = 1'b1; rw_n_b = 1'b1; addr_b = '0; wdata_b = '0;
    tick();
    chk("rst_busy_a",  32'(busy_a),  32'd1);
    chk("rst_ready_a", 32'(ready_a), 32'd0);
    chk("rst_rdata_a", 32'(rdata_a), 32'd0);
    chk("rst_valid_a", 32'(valid_a), 32'd0);
    chk("rst_busy_b",  32'(busy_b),  32'd0);
    chk("rst_ready_b", 32'(ready_b), 32'd1);
    chk("rst_valid_b", 32'(valid_b), 32'd0);
    rst = 1'b0; rst_b = 1'b0;

    // Clear sweep, with a write and a read offered mid-sweep that must be dropped.
    n = 0;
    while (busy_a && n < 3000) begin
      n++;
      if (n == 100) begin
        cs_n = 1'b0; rw_n = 1'b0; addr = 16'h0010; wdata = 8'hA5;
        #1;
        chk("busy_hit",   32'(hit_a),   32'd1);
        chk("busy_ready", 32'(ready_a), 32'd0);
      end else if (n == 101) begin
        cs_n = 1'b0; rw_n = 1'b1; addr = 16'h0010;
      end else begin
        cs_n = 1'b1; rw_n = 1'b1;
      end
      tick();
    end
    chk("busy_len",    32'(n),       32'd2048);
    chk("ready_after", 32'(ready_a), 32'd1);
    chk("busy_q_empty", 32'(qa.size()), 32'd0);

    rd_a(16'h0000, 8'h00);
    rd_a(16'h07FF, 8'h00);
    rd_a(16'h1234, 8'h00);
    rd_a(16'h0010, 8'h00);
    idle_a();
    chk("idle_valid", 32'(valid_a), 32'd0);

    // Mirrors of $0123 across the 8 KB window.
    wr_a(16'h0123, 8'h5A);
    rd_a(16'h0923, 8'h5A);
    rd_a(16'h1123, 8'h5A);
    rd_a(16'h1923, 8'h5A);
    idle_a();
    chk("hold_valid", 32'(valid_a), 32'd0);
    chk("hold_rdata", 32'(rdata_a), 32'h5A);

    cs_n = 1'b0; rw_n = 1'b0; addr = 16'h2123; wdata = 8'hFF;
    #1;
    chk("oow_hit", 32'(hit_a), 32'd0);
    tick();
    cs_n = 1'b1; rw_n = 1'b0; addr = 16'h0123; wdata = 8'h77;
    #1;
    chk("desel_hit", 32'(hit_a), 32'd0);
    tick();
    chk("desel_valid", 32'(valid_a), 32'd0);
    rd_a(16'h0123, 8'h5A);

    wr_a(16'h07FF, 8'h3C);
    rd_a(16'h07FF, 8'h3C);
    chk("wr_rd_data", 32'(rdata_a), 32'h3C);

    // Reset wins over a simultaneous read, then a second reset lands mid-sweep.
    cs_n = 1'b0; rw_n = 1'b1; addr = 16'h07FF; rst = 1'b1;
    tick();
    chk("rst_rd_rdata", 32'(rdata_a), 32'd0);
    chk("rst_rd_valid", 32'(valid_a), 32'd0);
    rst = 1'b0; cs_n = 1'b1;
    repeat (999) tick();
    chk("mid_busy_pre", 32'(busy_a), 32'd1);
    rst = 1'b1;
    tick();
    chk("mid_busy",  32'(busy_a),  32'd1);
    chk("mid_rdata", 32'(rdata_a), 32'd0);
    chk("mid_valid", 32'(valid_a), 32'd0);
    rst = 1'b0;
    n = 0;
    while (busy_a && n < 3000) begin
      n++;
      tick();
    end
    chk("busy_len_mid", 32'(n), 32'd2048);
    rd_a(16'h07FF, 8'h00);
    rd_a(16'h0123, 8'h00);
    idle_a();
    chk("qa_empty", 32'(qa.size()), 32'd0);

    // Instance without clear: usable straight after reset.
    cs_n_b = 1'b0; rw_n_b = 1'b0; addr_b = 16'h07FF; wdata_b = 8'h3C;
    tick();
    cs_n_b = 1'b0; rw_n_b = 1'b1; addr_b = 16'h07FF;
    qb.push_back(8'h3C);
    tick();
    chk("b_valid", 32'(valid_b), 32'd1);
    chk("b_rdata", 32'(rdata_b), 32'h3C);
    cs_n_b = 1'b1;
    tick();
    chk("b_valid_drop", 32'(valid_b), 32'd0);
    chk("qb_empty", 32'(qb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nes_bus_ram.md
Name: nes_bus_ram

Overview:
Parametrised synchronous RAM slave for the NES CPU bus. It generalises the fixed 64K RAM with configurable width, depth and decode window. It adds address mirroring, registered reads with a valid strobe, and a post-reset clear sequencer that initialises every location. Default configuration is the console's 2 KB work RAM at $0000, mirrored across $0000-$1FFF.

Parameters:
ADDR_W, 16, CPU address bus width
DATA_W, 8, data word width
DEPTH_LOG2, 11, log2 of storage words (2048)
WINDOW_LOG2, 13, log2 of decoded window size; storage mirrors within it; constraint DEPTH_LOG2 <= WINDOW_LOG2 <= ADDR_W
BASE_ADDR, 16'h0000, window base; bits below WINDOW_LOG2 ignored
CLEAR_ON_RESET, 1, 1 = run clear sequence after reset; 0 = skip it
CLEAR_VALUE, 8'h00, word written to every location by the clear sequence

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
addr  in  ADDR_W  CPU address
wdata  in  DATA_W  write data
rw_n  in  1  1 = read, 0 = write
cs_n  in  1  active-low chip select from bus decoder
rdata  out  DATA_W  registered read data
rdata_valid  out  1  one-cycle pulse; rdata holds new read result
hit  out  1  combinational: access addresses this window
ready  out  1  combinational: block accepts accesses (= !busy)
busy  out  1  registered: clear sequence in progress

Behaviour:
- Decode: hit = !cs_n && (addr[ADDR_W-1:WINDOW_LOG2] == BASE_ADDR[ADDR_W-1:WINDOW_LOG2]).
- Index: idx = addr[DEPTH_LOG2-1:0]. Bits WINDOW_LOG2-1:DEPTH_LOG2 are ignored, which produces the mirroring.
- Access accepted only when hit && ready. Accesses with !ready are dropped with no queueing, no write and no valid pulse.
- Write: accepted && !rw_n. On that edge, mem[idx] <= wdata.
- Read: accepted && rw_n. On that edge, rdata <= mem[idx] and rdata_valid <= 1, so data is visible one cycle after the request. rdata_valid returns to 0 on the next edge unless another read is accepted.
- Consecutive reads: back-to-back reads produce one valid pulse per cycle.
- Write then read: a read in cycle N+1 after a write in cycle N returns the new data.
- rdata holds its last value between reads.
- FSM states: CLEAR, IDLE.
  - On rst (highest priority, any state):
    - state <= CLEAR when CLEAR_ON_RESET = 1, else IDLE
    - clr_cnt <= 0
    - busy <= CLEAR_ON_RESET
    - rdata <= 0
    - rdata_valid <= 0
  - Memory contents are not touched by rst itself.
  - CLEAR: each cycle writes mem[clr_cnt] <= CLEAR_VALUE, then clr_cnt <= clr_cnt + 1. This takes exactly 2^DEPTH_LOG2 cycles.
  - CLEAR to IDLE: on the edge that writes the last index (clr_cnt = 2^DEPTH_LOG2 - 1), state <= IDLE and busy <= 0. With defaults, busy is high for exactly 2048 cycles after the cycle in which rst is sampled.
  - IDLE: serves bus accesses; stays in IDLE until rst.
- Reset mid-clear: the sequence restarts at index 0 and busy stays high for a full 2^DEPTH_LOG2 cycles from the new reset.
- Storage is one write port plus one registered read port. Clear writes and bus writes are mutually exclusive because of busy gating.
- Out-of-window or cs_n = 1: no storage change and no rdata_valid; rdata is held.
- rw_n and wdata values are don't-care when !hit.
- Arithmetic: clr_cnt is DEPTH_LOG2+1 bits wide, or wraps cleanly at DEPTH_LOG2 bits with an explicit terminal compare. No other arithmetic.

Test Plan:
- Clear check: pulse rst for 1 cycle, then read $0000, $07FF and $1234 after busy falls. Required: busy high for exactly 2048 cycles, every read returns 8'h00 with rdata_valid one cycle later.
- Write and mirror read: write 8'h5A to $0123, then read $0923, $1123 and $1923 on consecutive cycles. Required: rdata = 8'h5A each cycle, with three consecutive rdata_valid pulses.
- Out-of-window access: write 8'hFF to $2123, then read $0123. Required: hit = 0 during the $2123 write; the read returns 8'h5A.
- Access while busy: write 8'hA5 to $0010 at cycle 100 after rst. Required: ready = 0 and no rdata_valid; after the clear completes, reading $0010 returns 8'h00.
- Reset mid-clear: assert rst at cycle 1000 of the clear sequence. Required: busy stays high for 2048 more cycles, and rdata and rdata_valid are 0 in the cycle after rst.
- Write then read same address: write 8'h3C to $07FF in cycle N, read $07FF in cycle N+1. Required: rdata = 8'h3C with rdata_valid = 1 at N+2. Repeat with CLEAR_ON_RESET = 0; required: busy = 0 and ready = 1 immediately after rst.
